// File: rtl/roll_ci_master.sv
// Issues N back-to-back dice-roll custom-instruction transactions per request and accumulates sum/min/max.
// Latency: N*(1+k) + (N-1)*GAP_CYCLES + 1 cycles from acceptance to o_valid (k = slave done latency).
// Backpressure: o_ready only in IDLE; requests while busy are dropped, slave stalls bounded by TIMEOUT_CYCLES.
module roll_ci_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [3:0]  i_dieSelect,
    input  logic [3:0]  i_count,
    output logic        o_ready,
    output logic        o_busy,
    output logic        ci_clk_en,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    output logic [31:0] ci_datab,
    input  logic [31:0] ci_result,
    input  logic        ci_done,
    output logic        o_valid,
    output logic [8:0]  o_sum,
    output logic [4:0]  o_min,
    output logic [4:0]  o_max,
    output logic [3:0]  o_rolls,
    output logic        o_timeout
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    die_q;
    logic [3:0]    count_q;
    logic [7:0]    timer_q;
    logic [GW-1:0] gap_q;

    logic          accept;
    logic          roll_done;
    logic          tmo_hit;
    logic [3:0]    rolls_inc;
    logic [4:0]    roll_val;
    logic          unused_result_bits;

    assign roll_val           = ci_result[4:0];
    assign unused_result_bits = ^ci_result[31:5];
    assign rolls_inc          = o_rolls + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ci_done is only meaningful in WAIT; ISSUE/GAP/DONE/IDLE never look at it.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        roll_done = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    accept  = 1'b1;
                    state_d = (i_count == 4'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ci_done) begin
                    roll_done = 1'b1;
                    state_d   = (rolls_inc == count_q) ? S_DONE : S_GAP;
                end else if (timer_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result registers keep the previous batch visible until the next acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            die_q     <= 4'd0;
            count_q   <= 4'd0;
            o_sum     <= 9'd0;
            o_min     <= 5'h1F;
            o_max     <= 5'd0;
            o_rolls   <= 4'd0;
            o_timeout <= 1'b0;
        end else begin
            if (accept) begin
                die_q     <= i_dieSelect;
                count_q   <= i_count;
                o_sum     <= 9'd0;
                o_min     <= 5'h1F;
                o_max     <= 5'd0;
                o_rolls   <= 4'd0;
                o_timeout <= 1'b0;
            end
            if (roll_done) begin
                o_sum   <= o_sum + {4'd0, roll_val};
                o_rolls <= rolls_inc;
                if (roll_val < o_min) begin
                    o_min <= roll_val;
                end
                if (roll_val > o_max) begin
                    o_max <= roll_val;
                end
            end
            if (tmo_hit) begin
                o_timeout <= 1'b1;
            end
        end
    end

    // Timer counts WAIT cycles only; the gap counter runs only while in GAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= 8'd0;
            gap_q   <= '0;
        end else begin
            if (state_q == S_WAIT) begin
                timer_q <= timer_q + 8'd1;
            end else begin
                timer_q <= 8'd0;
            end
            if (state_q == S_GAP) begin
                gap_q <= gap_q + GW'(1);
            end else begin
                gap_q <= '0;
            end
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_busy    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_GAP);
    assign o_valid   = (state_q == S_DONE);
    assign ci_start  = (state_q == S_ISSUE);
    assign ci_clk_en = ~reset;
    // The completed-roll count doubles as the index of the roll in flight.
    assign ci_dataa  = {28'd0, die_q};
    assign ci_datab  = {28'd0, o_rolls};

endmodule

// File: tb/tb_roll_ci_master.sv
// Bench for roll_ci_master: randomized batches against a CI slave responder, results scored from a queue.
module tb_roll_ci_master;

    localparam int T = 255;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [3:0]  i_dieSelect;
    logic [3:0]  i_count;
    logic        o_ready;
    logic        o_busy;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic [31:0] ci_result;
    logic        ci_done;
    logic        o_valid;
    logic [8:0]  o_sum;
    logic [4:0]  o_min;
    logic [4:0]  o_max;
    logic [3:0]  o_rolls;
    logic        o_timeout;

    roll_ci_master #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_dieSelect(i_dieSelect), .i_count(i_count),
        .o_ready(o_ready), .o_busy(o_busy), .ci_clk_en(ci_clk_en), .ci_start(ci_start),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_result(ci_result), .ci_done(ci_done),
        .o_valid(o_valid), .o_sum(o_sum), .o_min(o_min), .o_max(o_max), .o_rolls(o_rolls),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sum;
        int mn;
        int mx;
        int rolls;
        int tmo;
        int cyc;
        int starts;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] res[16];
    int checks = 0;
    int errors = 0;

    // responder configuration for the batch in flight
    int r_k = 1;
    int r_ans = 0;
    bit r_hold = 1'b0;
    int r_die = 0;
    int start_idx = 0;
    int batch_starts = 0;

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // CI slave: done k cycles after a start, optionally holding done high outside the WAIT window.
    initial begin
        int cnt;
        cnt = 0;
        ci_done = 1'b0;
        ci_result = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
                ci_done = 1'b0;
                ci_result = 32'd0;
            end else if (ci_start) begin
                chk("ci_datab_index", ci_datab, start_idx);
                chk("ci_dataa_die", ci_dataa, r_die);
                start_idx++;
                batch_starts++;
                if (r_ans > 0) begin
                    r_ans--;
                    cnt = r_k;
                end else begin
                    cnt = 0;
                end
                ci_done = r_hold;
                ci_result = 32'd0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ci_done = 1'b1;
                    ci_result = (resp_q.size() > 0) ? resp_q.pop_front() : 32'd0;
                end else begin
                    ci_done = 1'b0;
                    ci_result = $urandom;
                end
            end else begin
                ci_done = r_hold;
                ci_result = r_hold ? 32'd0 : $urandom;
            end
        end
    end

    // Monitor: every o_valid pops one expected batch result.
    bit prev_start = 1'b0;
    bit ready_pending = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_start = 1'b0;
            ready_pending = 1'b0;
        end else begin
            if (ready_pending) begin
                chk("ready_after_valid", o_ready, 1);
                ready_pending = 1'b0;
            end
            if (ci_start) chk("start_one_cycle", prev_start, 0);
            prev_start = ci_start;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", o_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", o_sum, e.sum);
                    chk("min", o_min, e.mn);
                    chk("max", o_max, e.mx);
                    chk("rolls", o_rolls, e.rolls);
                    chk("timeout", o_timeout, e.tmo);
                    chk("valid_cycle", cyc, e.cyc);
                    chk("start_count", batch_starts, e.starts);
                    chk("busy_at_valid", o_busy, 0);
                    chk("ready_at_valid", o_ready, 0);
                    ready_pending = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!o_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!o_ready) chk("ready_wait_expired", o_ready, 1);
    endtask

    // Reference: fold the answered results; latency from roll/gap/timeout counts.
    task automatic run_batch(int n, int die, int k, int j, bit hold, bit glitch);
        exp_t e;
        int v;
        int guard;
        @(posedge clk); #1;
        wait_ready();
        e.sum = 0; e.mn = 31; e.mx = 0; e.rolls = j; e.tmo = (j < n) ? 1 : 0;
        for (int i = 0; i < j; i++) begin
            v = int'(res[i] & 32'h1F);
            e.sum += v;
            if (v < e.mn) e.mn = v;
            if (v > e.mx) e.mx = v;
        end
        e.starts = (j < n) ? j + 1 : n;
        r_k = k; r_ans = j; r_hold = hold; r_die = die;
        start_idx = 0; batch_starts = 0;
        resp_q.delete();
        for (int i = 0; i < j; i++) resp_q.push_back(res[i]);
        i_dieSelect = 4'(die); i_count = 4'(n); i_req = 1'b1;
        if (n == 0)      e.cyc = cyc + 1;
        else if (j == n) e.cyc = cyc + 1 + n * (1 + k) + (n - 1) * G;
        else             e.cyc = cyc + 1 + j * (1 + k + G) + 1 + T;
        exp_q.push_back(e);
        @(posedge clk); #1;
        i_req = 1'b0; i_dieSelect = 4'($urandom); i_count = 4'($urandom);
        if (glitch) begin
            repeat (2) @(posedge clk);
            #1 i_req = 1'b1;
            @(posedge clk); #1;
            i_req = 1'b0;
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() > 0) begin
            chk("valid_wait_expired", exp_q.size(), 0);
            exp_q.delete();
        end
        r_hold = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", ci_start, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_sum", o_sum, 0);
        chk("rst_min", o_min, 31);
        chk("rst_max", o_max, 0);
        chk("rst_rolls", o_rolls, 0);
        chk("rst_dataa", ci_dataa, 0);
        chk("rst_datab", ci_datab, 0);
        chk("rst_clk_en", ci_clk_en, 1);
    endtask

    initial begin
        int n, k, j;
        bit hold;
        reset = 1'b1; i_req = 1'b0; i_dieSelect = 4'd0; i_count = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("clk_en_in_reset", ci_clk_en, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // rolls 4,6,1 on die 4 with two-cycle done latency
        res[0] = ($urandom & 32'hFFFF_FFE0) | 32'd4;
        res[1] = ($urandom & 32'hFFFF_FFE0) | 32'd6;
        res[2] = ($urandom & 32'hFFFF_FFE0) | 32'd1;
        run_batch(3, 4, 2, 3, 1'b0, 1'b0);

        run_batch(0, 9, 1, 0, 1'b0, 1'b0);

        // slave never answers
        run_batch(2, 3, 2, 0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) res[i] = 32'hFFFF_FFFF;
        run_batch(15, 15, 1, 15, 1'b0, 1'b0);

        // done held high through GAP/ISSUE plus a stray request mid-batch
        for (int i = 0; i < 4; i++) res[i] = $urandom;
        run_batch(4, 2, 2, 4, 1'b1, 1'b1);

        // reset during the second roll's WAIT
        @(posedge clk); #1;
        wait_ready();
        for (int i = 0; i < 5; i++) res[i] = ($urandom & 32'hFFFF_FFE0) | 32'd20;
        r_k = 2; r_ans = 5; r_hold = 1'b0; r_die = 7; start_idx = 0; batch_starts = 0;
        resp_q.delete();
        for (int i = 0; i < 5; i++) resp_q.push_back(res[i]);
        i_dieSelect = 4'd7; i_count = 4'd5; i_req = 1'b1;
        @(posedge clk); #1 i_req = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_sum_before_reset", o_sum, 20);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        repeat (12) @(posedge clk);

        for (int b = 0; b < 20; b++) begin
            n = $urandom_range(0, 15);
            k = $urandom_range(1, 4);
            j = n;
            if (n > 0 && $urandom_range(0, 4) == 0) j = $urandom_range(0, n - 1);
            hold = (j == n) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < 16; i++) res[i] = $urandom;
            run_batch(n, $urandom_range(0, 15), k, j, hold, (n >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
